// File: rtl/ped_signal_ctrl.sv
// ped_signal_ctrl: pedestrian crossing controller slaved to the vehicle light FSM,
// with debounced request latch, WALK/flashing-clearance phases and 2-digit countdown.
module ped_signal_ctrl #(
  parameter int WALK_TIME  = 40,
  parameter int CLEAR_TIME = 15,
  parameter int DEBOUNCE   = 4,
  parameter int FLASH_DIV  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic       req_pending,
  output logic       fault,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones
);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int FW = $clog2(FLASH_DIV + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE - 1);
  localparam logic [FW-1:0] FL_MAX = FW'(FLASH_DIV - 1);
  localparam logic [6:0] WALK_LOAD  = 7'(WALK_TIME - 1);
  localparam logic [6:0] CLEAR_LOAD = 7'(CLEAR_TIME - 1);

  typedef enum logic [1:0] {P_STOP, P_WALK, P_CLEAR, P_FAULT} state_t;

  state_t          st_q, st_d;
  logic            s1_q, s2_q, btn_db_q, btn_db_d, btn_prev_q, red_q;
  logic            req_q, req_d, walk_q, walk_d, dw_q, dw_d, fault_q, fault_d;
  logic [DW-1:0]   db_cnt_q, db_cnt_d;
  logic [FW-1:0]   fl_cnt_q, fl_cnt_d;
  logic [6:0]      cnt_q, cnt_d, disp, seg_tens_q, seg_tens_d, seg_ones_q, seg_ones_d;
  logic [3:0]      tens, ones;
  logic            red_rise, db_rise, grant, show;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  always_comb begin
    red_rise = red & ~red_q;
    db_rise  = btn_db_q & ~btn_prev_q;
    db_cnt_d = (s2_q == btn_db_q || db_cnt_q == DB_MAX) ? '0 : db_cnt_q + DW'(1);
    btn_db_d = (s2_q != btn_db_q && db_cnt_q == DB_MAX) ? s2_q : btn_db_q;
    st_d     = st_q;
    cnt_d    = cnt_q;
    grant    = 1'b0;
    case (st_q)
      P_STOP: if (red_rise && req_q) begin
        st_d  = P_WALK;
        cnt_d = WALK_LOAD;
        grant = 1'b1;
      end
      P_WALK: if (!red) st_d = P_STOP;
        else if (cnt_q == 7'd0) begin
          st_d  = P_CLEAR;
          cnt_d = CLEAR_LOAD;
        end else cnt_d = cnt_q - 7'd1;
      P_CLEAR: if (!red || cnt_q == 7'd0) st_d = P_STOP;
        else cnt_d = cnt_q - 7'd1;
      default: st_d = P_FAULT;
    endcase
    // any non-one-hot light sample locks the crossing to DON'T WALK
    if (!$onehot({red, yellow, green})) st_d = P_FAULT;
    fl_cnt_d   = (st_q != P_CLEAR || fl_cnt_q == FL_MAX) ? '0 : fl_cnt_q + FW'(1);
    dw_d       = st_d == P_WALK ? 1'b0 :
                 st_d != P_CLEAR || st_q != P_CLEAR ? 1'b1 :
                 fl_cnt_q == FL_MAX ? ~dw_q : dw_q;
    walk_d     = st_d == P_WALK;
    fault_d    = st_d == P_FAULT;
    req_d      = st_d == P_FAULT ? 1'b0 : (req_q & ~grant) | db_rise;
    disp       = cnt_d > 7'd98 ? 7'd99 : cnt_d + 7'd1;
    tens       = 4'(disp / 7'd10);
    ones       = 4'(disp % 7'd10);
    show       = st_d == P_WALK || st_d == P_CLEAR;
    seg_tens_d = show && tens != 4'd0 ? seg7(tens) : 7'd0;
    seg_ones_d = show ? seg7(ones) : 7'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q       <= P_STOP;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      btn_db_q   <= 1'b0;
      btn_prev_q <= 1'b0;
      db_cnt_q   <= '0;
      fl_cnt_q   <= '0;
      cnt_q      <= 7'd0;
      red_q      <= 1'b0;
      req_q      <= 1'b0;
      walk_q     <= 1'b0;
      dw_q       <= 1'b1;
      fault_q    <= 1'b0;
      seg_tens_q <= 7'd0;
      seg_ones_q <= 7'd0;
    end else begin
      st_q       <= st_d;
      s1_q       <= ped_btn;
      s2_q       <= s1_q;
      btn_db_q   <= btn_db_d;
      btn_prev_q <= btn_db_q;
      db_cnt_q   <= db_cnt_d;
      fl_cnt_q   <= fl_cnt_d;
      cnt_q      <= cnt_d;
      red_q      <= red;
      req_q      <= req_d;
      walk_q     <= walk_d;
      dw_q       <= dw_d;
      fault_q    <= fault_d;
      seg_tens_q <= seg_tens_d;
      seg_ones_q <= seg_ones_d;
    end
  end

  assign walk        = walk_q;
  assign dont_walk   = dw_q;
  assign req_pending = req_q;
  assign fault       = fault_q;
  assign seg_tens    = seg_tens_q;
  assign seg_ones    = seg_ones_q;
endmodule
